// File: rtl/zbus_io_responder.sv
// zbus_io_responder: Z80 I/O-cycle target that turns synchronised IORQ/RD/WR strobes into one-clk register strobes
module zbus_io_responder #(
    parameter logic [7:0] PORT_LO  = 8'hAB,
    parameter int         REG_BITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [15:0]         za,
    input  logic [7:0]          zd_in,
    output logic [7:0]          zd_out,
    output logic                zd_oe,
    input  logic                ziorq_n,
    input  logic                zrd_n,
    input  logic                zwr_n,
    input  logic                zm1_n,
    output logic [REG_BITS-1:0] reg_addr,
    output logic [7:0]          reg_wdata,
    output logic                reg_wr,
    output logic                reg_rd,
    input  logic [7:0]          reg_rdata
);
    typedef enum logic [1:0] {WAIT_IDLE, IDLE, RD_REQ, HOLD} state_t;
    state_t     state_q;
    logic [1:0] iorq_q, rd_q, wr_q, m1_q;
    logic       oe_q, armed_q;
    logic       s_iorq_n, s_rd_n, s_wr_n, s_m1_n;
    logic       hit, s_idle, first_idle;
    logic       unused_za;
    assign s_iorq_n   = iorq_q[1];
    assign s_rd_n     = rd_q[1];
    assign s_wr_n     = wr_q[1];
    assign s_m1_n     = m1_q[1];
    assign s_idle     = s_iorq_n & s_rd_n & s_wr_n;
    assign first_idle = iorq_q[0] & rd_q[0] & wr_q[0];
    assign hit        = !s_iorq_n && s_m1_n && za[7:0] == PORT_LO;
    assign zd_oe      = oe_q & !zrd_n & !ziorq_n;
    assign unused_za  = ^za[15:8];
    // Two-flop synchronisers for the asynchronous Z80 strobes, idle-high out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            iorq_q <= 2'b11;
            rd_q   <= 2'b11;
            wr_q   <= 2'b11;
            m1_q   <= 2'b11;
        end else begin
            iorq_q <= {iorq_q[0], ziorq_n};
            rd_q   <= {rd_q[0], zrd_n};
            wr_q   <= {wr_q[0], zwr_n};
            m1_q   <= {m1_q[0], zm1_n};
        end
    end
    // Cycle FSM; armed_q blocks the first post-reset cycle, when both sync stages still hold their reset ones
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= WAIT_IDLE;
            armed_q   <= 1'b0;
            reg_wr    <= 1'b0;
            reg_rd    <= 1'b0;
            oe_q      <= 1'b0;
            zd_out    <= 8'hFF;
            reg_addr  <= '0;
            reg_wdata <= 8'h00;
        end else begin
            armed_q <= 1'b1;
            reg_wr  <= 1'b0;
            reg_rd  <= 1'b0;
            case (state_q)
                WAIT_IDLE: if (armed_q && s_idle && first_idle) state_q <= IDLE;
                IDLE: begin
                    if (hit && !s_wr_n && s_rd_n) begin
                        reg_addr  <= za[8 +: REG_BITS];
                        reg_wdata <= zd_in;
                        reg_wr    <= 1'b1;
                        state_q   <= HOLD;
                    end else if (hit && !s_rd_n && s_wr_n) begin
                        reg_addr <= za[8 +: REG_BITS];
                        reg_rd   <= 1'b1;
                        state_q  <= RD_REQ;
                    end else if (hit && !s_rd_n && !s_wr_n) begin
                        state_q <= HOLD;
                    end
                end
                RD_REQ: begin
                    zd_out  <= reg_rdata;
                    oe_q    <= 1'b1;
                    state_q <= HOLD;
                end
                default: begin
                    if (s_idle) begin
                        oe_q    <= 1'b0;
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_zbus_io_responder.sv
// tb_zbus_io_responder: scoreboard bench driving Z80 bus cycles against the I/O responder
module tb_zbus_io_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] za;
    logic [7:0]  zd_in, zd_out, reg_wdata, reg_rdata;
    logic        zd_oe, ziorq_n, zrd_n, zwr_n, zm1_n, reg_wr, reg_rd;
    logic [2:0]  reg_addr;
    logic [7:0]  regs [8];

    typedef struct {logic wr; logic [2:0] addr; logic [7:0] data;} txn_t;
    txn_t       sq[$];
    logic [7:0] rdq[$];
    int         tests = 0, fails = 0;
    bit         oe_allow = 1'b0;
    logic       oe_prev = 1'b0;

    zbus_io_responder #(.PORT_LO(8'hAB), .REG_BITS(3)) dut (
        .clk(clk), .rst(rst), .za(za), .zd_in(zd_in), .zd_out(zd_out), .zd_oe(zd_oe),
        .ziorq_n(ziorq_n), .zrd_n(zrd_n), .zwr_n(zwr_n), .zm1_n(zm1_n),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
        .reg_rdata(reg_rdata)
    );

    always #5 clk = ~clk;

    // register-bank model: write on reg_wr, read data presented from the addressed entry
    assign reg_rdata = regs[reg_addr];
    always @(posedge clk) if (reg_wr) regs[reg_addr] <= reg_wdata;

    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // monitor: pop expected strobes and read data as the DUT presents them
    always @(negedge clk) begin
        txn_t t;
        if (!rst) begin
            if (reg_wr || reg_rd) begin
                if (sq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_strobe: got wr=%b rd=%b addr=%0d expected none", reg_wr, reg_rd, reg_addr);
                end else begin
                    t = sq.pop_front();
                    chk("strobe_kind", {14'd0, reg_wr, reg_rd}, {14'd0, t.wr, !t.wr});
                    chk("reg_addr", {13'd0, reg_addr}, {13'd0, t.addr});
                    if (t.wr) chk("reg_wdata", {8'd0, reg_wdata}, {8'd0, t.data});
                end
            end
            if (zd_oe && !oe_prev) begin
                if (rdq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_oe: got zd_oe=1 expected 0");
                end else chk("zd_out", {8'd0, zd_out}, {8'd0, rdq.pop_front()});
            end
            if (!oe_allow) chk("zd_oe_quiet", {15'd0, zd_oe}, 16'd0);
        end
        oe_prev = zd_oe;
    end

    task automatic iocyc(input logic [15:0] a, input logic [7:0] d,
                         input logic iorq, input logic rd, input logic wr, input logic m1,
                         input int hold, input int gap);
        za = a; zd_in = d; zm1_n = m1; ziorq_n = iorq; zrd_n = rd; zwr_n = wr;
        repeat (hold) @(negedge clk);
        ziorq_n = 1'b1; zrd_n = 1'b1; zwr_n = 1'b1; zm1_n = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic iowr(input logic [15:0] a, input logic [7:0] d, input int gap);
        sq.push_back('{1'b1, a[10:8], d});
        iocyc(a, d, 1'b0, 1'b1, 1'b0, 1'b1, 8, gap);
    endtask

    task automatic iord(input logic [15:0] a, input logic [7:0] exp, input int gap);
        sq.push_back('{1'b0, a[10:8], 8'h00});
        rdq.push_back(exp);
        oe_allow = 1'b1;
        za = a; ziorq_n = 1'b0; zrd_n = 1'b0;
        repeat (8) @(negedge clk);
        chk("cpu_oe", {15'd0, zd_oe}, 16'd1);
        chk("cpu_zd", {8'd0, zd_out}, {8'd0, exp});
        zrd_n = 1'b1; ziorq_n = 1'b1;
        #1 chk("oe_release", {15'd0, zd_oe}, 16'd0);
        oe_allow = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) regs[i] = 8'h00;
        regs[5] = 8'h5A;
        regs[3] = 8'h3C;
        rst = 1'b1; za = 16'h0000; zd_in = 8'h00;
        ziorq_n = 1'b1; zrd_n = 1'b1; zwr_n = 1'b1; zm1_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_reg_wr", {15'd0, reg_wr}, 16'd0);
        chk("rst_reg_rd", {15'd0, reg_rd}, 16'd0);
        chk("rst_zd_oe", {15'd0, zd_oe}, 16'd0);
        chk("rst_zd_out", {8'd0, zd_out}, 16'h00FF);
        chk("rst_reg_addr", {13'd0, reg_addr}, 16'd0);
        chk("rst_reg_wdata", {8'd0, reg_wdata}, 16'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        iowr(16'h02AB, 8'h99, 6);
        iord(16'h05AB, 8'h5A, 6);
        iocyc(16'h2222, 8'h99, 1'b0, 1'b1, 1'b0, 1'b1, 8, 6);
        iocyc(16'h12AB, 8'hAB, 1'b1, 1'b1, 1'b0, 1'b1, 8, 6);
        iocyc(16'h11AB, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8, 6);
        iocyc(16'h00AB, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8, 6);
        iowr(16'h01AB, 8'h11, 3);
        iord(16'h01AB, 8'h11, 6);

        sq.push_back('{1'b0, 3'd3, 8'h00});
        rdq.push_back(8'h3C);
        oe_allow = 1'b1;
        za = 16'h03AB; ziorq_n = 1'b0; zrd_n = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_rst_oe", {15'd0, zd_oe}, 16'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_oe", {15'd0, zd_oe}, 16'd0);
        chk("midrst_zd_out", {8'd0, zd_out}, 16'h00FF);
        chk("midrst_reg_addr", {13'd0, reg_addr}, 16'd0);
        rst = 1'b0;
        oe_allow = 1'b0;
        repeat (10) @(negedge clk);
        ziorq_n = 1'b1; zrd_n = 1'b1;
        repeat (6) @(negedge clk);
        iord(16'h03AB, 8'h3C, 6);

        chk("strobes_pending", 16'(sq.size()), 16'd0);
        chk("reads_pending", 16'(rdq.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/zbus_io_responder.md
# zbus_io_responder

Synthesizable Z80 I/O-cycle responder: the target side of the bus that the `ssz80` model and the CPU drive. It oversamples the asynchronous Z80 strobes on the fast system clock and decodes I/O reads and writes to a configurable port. It converts them into single-cycle register-file strobes on the internal side, and drives read data back onto the Z80 data bus with a gated output enable. It sits in `top` between the Z80 pins and the internal register bank.

## Interface
Parameters:
- PORT_LO, 8'hAB, low address byte (za[7:0]) that selects this block.
- REG_BITS, 3, register index width, taken from za[8 +: REG_BITS].

Ports:
- clk  in  1  system clock; must be ≥ 8× the Z80 clock.
- rst  in  1  reset, synchronous, active-high.
- za  in  16  Z80 address bus.
- zd_in  in  8  Z80 data bus, input path.
- zd_out  out  8  read data toward the Z80 bus.
- zd_oe  out  1  data bus output enable; the pad is driven when this is 1.
- ziorq_n, zrd_n, zwr_n, zm1_n  in  1 each  raw asynchronous Z80 strobes.
- reg_addr  out  REG_BITS  register index of the current access.
- reg_wdata  out  8  write data.
- reg_wr  out  1  one-clk write strobe.
- reg_rd  out  1  one-clk read strobe.
- reg_rdata  in  8  read data; valid exactly 1 clk after reg_rd.

## Operation
- Synchronizer: each of ziorq_n, zrd_n, zwr_n and zm1_n passes through a 2-FF chain; the outputs are s_iorq_n, s_rd_n, s_wr_n and s_m1_n. Sync flops reset to 1.
- The `hit` condition is: !s_iorq_n, s_m1_n, and za[7:0]==PORT_LO. za and zd_in are sampled directly; the Z80 holds them stable while the strobe is low.
- FSM states are WAIT_IDLE, IDLE, RD_REQ and HOLD.
  - WAIT_IDLE: this is the reset state. Go to IDLE once s_iorq_n, s_rd_n and s_wr_n are all 1. This discards any cycle that was in progress at reset.
  - IDLE, write case (hit & !s_wr_n & s_rd_n): latch reg_addr and reg_wdata<=zd_in, pulse reg_wr, go to HOLD.
  - IDLE, read case (hit & !s_rd_n & s_wr_n): latch reg_addr, pulse reg_rd, go to RD_REQ.
  - IDLE, illegal case (hit & !s_rd_n & !s_wr_n): no strobes, go to HOLD.
  - RD_REQ: zd_out<=reg_rdata, oe_reg<=1, go to HOLD. This happens unconditionally.
  - HOLD: when s_iorq_n, s_rd_n and s_wr_n are all 1, clear oe_reg and go to IDLE.
- zd_oe = oe_reg & !zrd_n & !ziorq_n, using the raw pins combinationally. Release is therefore immediate on RD rising, with no synchronizer lag and no contention.
- Ignored, with no strobes and zd_oe=0:
  - memory cycles (ziorq_n=1);
  - interrupt acknowledge (zm1_n=0 while ziorq_n=0);
  - non-matching za[7:0].
- Exactly one reg_wr or reg_rd per Z80 cycle, regardless of strobe length.

## Timing
- Reset values:
  - state WAIT_IDLE;
  - reg_wr 0, reg_rd 0, oe_reg 0, zd_oe 0;
  - zd_out 8'hFF, reg_addr 0, reg_wdata 0.
- Edge numbering: edge 0 is the first clk edge that samples a raw strobe low. s_* is low after edge 1. The FSM acts at edge 2.
- Write latency: reg_wr is high for the cycle following edge 2, with reg_addr and reg_wdata valid in that same cycle.
- Read latency:
  - reg_rd is high for the cycle following edge 2.
  - reg_rdata is sampled at edge 3.
  - zd_out is valid and zd_oe is high after edge 3, for as long as the raw RD and IORQ stay low.
- Strobe ends: HOLD exits 2–3 clk after the raw strobe rises. A back-to-back I/O cycle is accepted once IDLE is reached.
- Reset mid-cycle: outputs return to reset values at the next edge. The interrupted Z80 cycle produces no strobe, and the next strobe is recognised only after a full release.
- RD abort during RD_REQ: the raw-pin gate keeps zd_oe at 0, and the FSM still passes through HOLD normally.

## Test plan
- I/O write: iowr(16'h02AB, 8'h99) -> exactly one reg_wr pulse with reg_addr=2 and reg_wdata=8'h99; reg_rd stays 0.
- I/O read: the model returns 8'h5A one clk after reg_rd; iord(16'h05AB) -> reg_addr=5, one reg_rd, zd=8'h5A captured by the CPU, zd_oe falls in the same timestep that zrd_n rises.
- Non-target cycles produce no strobes and zd_oe stays 0 throughout:
  - iowr(16'h2222, 8'h99);
  - memwr(16'h12AB, 8'hAB);
  - memrd(16'h11AB);
  - an INTA cycle (zm1_n=0, ziorq_n=0, za=16'h00AB).
- Back-to-back: iowr(16'h01AB, 8'h11) immediately followed by iord(16'h01AB) -> one reg_wr, then one reg_rd; zd_out returns the model's value.
- Reset mid-read: assert rst for 1 clk while zrd_n=0 and ziorq_n=0 on port 16'h03AB ->
  - zd_oe drops at the next edge;
  - no reg_rd for the remainder of that cycle;
  - the next iord(16'h03AB) is serviced normally.
